// File: rtl/line_fill_memory.sv
// line_fill_memory: memory-side responder for the cache line-fill read path.
// It accepts line-aligned read requests and queues up to FifoDepth of them.
// Each request is answered with a full line and a single-cycle valid pulse,
// a fixed Latency after the request becomes the head of the queue.
// A word write port preloads the storage or updates it from the backdoor.
// Optional feature: define LINE_FILL_MEM_STALL_EN to add a stall_i input.
// While stall_i is high it freezes the latency countdown and holds off a due response.
module line_fill_memory #(
    parameter int MemWords       = 1024,
    parameter int NrWordsPerLine = 4,
    parameter int LineSize       = 32 * NrWordsPerLine,
    parameter int Latency        = 4,
    parameter int FifoDepth      = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef LINE_FILL_MEM_STALL_EN
    input  logic                stall_i,
`endif
    input  logic [31:0]         mem_addr_i,
    input  logic                mem_read_en_i,
    output logic                mem_read_ready_o,
    output logic                mem_read_valid_o,
    output logic [LineSize-1:0] mem_read_data_o,
    input  logic                write_en_i,
    input  logic [31:0]         write_addr_i,
    input  logic [31:0]         write_data_i,
    output logic                drop_o
);

    localparam int AW = $clog2(MemWords);
    localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CW = $clog2(FifoDepth + 1);
    localparam int TW = (Latency > 1) ? $clog2(Latency) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0]   r_mem [MemWords];
    logic [AW-1:0] r_queue [FifoDepth];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_counter;
    logic [1:0]    r_state;
    logic          r_drop;

    logic                w_stall;
    logic                w_ready;
    logic                w_accept;
    logic                w_respFire;
    logic [AW-1:0]       w_reqBase;
    logic [AW-1:0]       w_writeIdx;
    logic [AW-1:0]       w_headBase;
    logic [AW-1:0]       w_wordIdx;
    logic [LineSize-1:0] w_lineData;
    logic                w_unused;

`ifdef LINE_FILL_MEM_STALL_EN
    assign w_stall = stall_i;
`else
    assign w_stall = 1'b0;
`endif

    // Address bits below line/word granularity are don't-care by definition.
    assign w_unused = ^{mem_addr_i, write_addr_i};

    // Readiness uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign w_ready    = (r_count < CW'(FifoDepth));
    assign w_accept   = mem_read_en_i && w_ready;
    assign w_respFire = (r_state == ST_RESP) && !w_stall;

    // Line and word indices wrap silently at the storage size.
    assign w_reqBase  = AW'(mem_addr_i[31:4] * NrWordsPerLine);
    assign w_writeIdx = AW'(write_addr_i[31:2]);
    assign w_headBase = r_queue[r_rdPtr];

    assign mem_read_ready_o = w_ready;
    assign mem_read_valid_o = w_respFire;
    assign mem_read_data_o  = w_lineData;
    assign drop_o           = r_drop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        if (p == PW'(FifoDepth - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Assemble the head line straight from storage; the bus reads zero outside the response cycle.
    always_comb begin
        w_lineData = '0;
        w_wordIdx  = '0;
        if (w_respFire) begin
            for (int k = 0; k < NrWordsPerLine; k++) begin
                w_wordIdx = w_headBase + AW'(k);
                w_lineData[32*k +: 32] = r_mem[w_wordIdx];
            end
        end
    end

    // Storage is deliberately left out of reset; writes are simply ignored during the reset cycle.
    always_ff @(posedge clk_i) begin
        if (write_en_i && !rst_i) begin
            r_mem[w_writeIdx] <= write_data_i;
        end
    end

    // Request queue: push on acceptance and pop when the head response goes out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_queue[r_wrPtr] <= w_reqBase;
                r_wrPtr          <= nextPtr(r_wrPtr);
            end
            if (w_respFire) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            r_count <= r_count + CW'(w_accept) - CW'(w_respFire);
        end
    end

    // The drop flag is sticky and is cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop <= 1'b0;
        end else if (mem_read_en_i && !w_ready) begin
            r_drop <= 1'b1;
        end
    end

    // Response sequencer: count Latency cycles for the head entry, then fire the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (Latency == 1) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_counter <= TW'(Latency - 1);
                            r_state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_stall) begin
                        r_counter <= r_counter - TW'(1);
                        if (r_counter == TW'(1)) begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (!w_stall) begin
                        if ((r_count > CW'(1)) || w_accept) begin
                            if (Latency == 1) begin
                                r_state <= ST_RESP;
                            end else begin
                                r_counter <= TW'(Latency - 1);
                                r_state   <= ST_WAIT;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_memory.sv
// tb_line_fill_memory: directed bench for line_fill_memory with default parameters.
// A monitor logs every response cycle and its line, and the directed sequences compare
// those logs against hand-computed cycles and data.
module tb_line_fill_memory;

    logic         clk;
    logic         rst;
    logic [31:0]  memAddr;
    logic         memReadEn;
    logic         memReadReady;
    logic         memReadValid;
    logic [127:0] memReadData;
    logic         writeEn;
    logic [31:0]  writeAddr;
    logic [31:0]  writeData;
    logic         drop;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int reqCyc;

    logic lastReady;
    logic lastDrop;

    int           respCyc[$];
    logic [127:0] respData[$];

    localparam logic [127:0] LINE40    = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE40NEW = 128'h44444444_33333333_22222222_DEADBEEF;
    localparam logic [127:0] LINE00    = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;

    line_fill_memory dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_addr_i       (memAddr),
        .mem_read_en_i    (memReadEn),
        .mem_read_ready_o (memReadReady),
        .mem_read_valid_o (memReadValid),
        .mem_read_data_o  (memReadData),
        .write_en_i       (writeEn),
        .write_addr_i     (writeAddr),
        .write_data_i     (writeData),
        .drop_o           (drop)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: during the cycle that follows edge k, cyc equals k.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every response in the middle of its cycle.
    always @(negedge clk) begin
        if (memReadValid === 1'b1) begin
            respCyc.push_back(cyc);
            respData.push_back(memReadData);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, sample ready/drop mid-cycle, then advance past the next edge.
    task automatic applyStimulus(input logic readEn, input logic [31:0] readAddr,
                                 input logic wEn, input logic [31:0] wAddr, input logic [31:0] wData);
        memReadEn = readEn;
        memAddr   = readAddr;
        writeEn   = wEn;
        writeAddr = wAddr;
        writeData = wData;
        @(negedge clk);
        lastReady = memReadReady;
        lastDrop  = drop;
        @(posedge clk);
        #1;
        memReadEn = 1'b0;
        writeEn   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic clearLog();
        respCyc.delete();
        respData.delete();
    endtask

    initial begin
        rst       = 1'b1;
        memAddr   = '0;
        memReadEn = 1'b0;
        writeEn   = 1'b0;
        writeAddr = '0;
        writeData = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("resetValid", 128'(memReadValid), 128'(0));
        checkOutput("resetData",  memReadData, 128'(0));
        checkOutput("resetReady", 128'(memReadReady), 128'(1));
        checkOutput("resetDrop",  128'(drop), 128'(0));

        // Preload line 0x40, and line 0 partly through the wrapped alias 0x1004.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'h11111111);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h44, 32'h22222222);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h48, 32'h33333333);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h4C, 32'h44444444);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00, 32'hA0A0A0A0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1004, 32'hB1B1B1B1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h08, 32'hC2C2C2C2);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0C, 32'hD3D3D3D3);

        // Second reset must keep storage intact.
        doReset();
        clearLog();
        checkOutput("reset2Ready", 128'(memReadReady), 128'(1));

        // Single request with an unaligned address.
        reqCyc = cyc;
        applyStimulus(1'b1, 32'h00000047, 1'b0, 32'h0, 32'h0);
        checkOutput("singleReady", 128'(lastReady), 128'(1));
        idle(7);
        checkOutput("singleCount", 128'(respCyc.size()), 128'(1));
        if (respCyc.size() >= 1) begin
            checkOutput("singleLatency", 128'(respCyc[0] - reqCyc), 128'(4));
            checkOutput("singleData", respData[0], LINE40);
        end
        checkOutput("idleValid", 128'(memReadValid), 128'(0));
        checkOutput("idleData",  memReadData, 128'(0));

        // Three back-to-back requests; the third overflows the two-entry queue.
        clearLog();
        reqCyc = cyc;
        applyStimulus(1'b1, 32'h00000040, 1'b0, 32'h0, 32'h0);
        checkOutput("burstReady0", 128'(lastReady), 128'(1));
        applyStimulus(1'b1, 32'h00001000, 1'b0, 32'h0, 32'h0);
        checkOutput("burstReady1", 128'(lastReady), 128'(1));
        applyStimulus(1'b1, 32'h00000040, 1'b0, 32'h0, 32'h0);
        checkOutput("burstReady2", 128'(lastReady), 128'(0));
        checkOutput("burstDropBefore", 128'(lastDrop), 128'(0));
        checkOutput("burstDropAfter", 128'(drop), 128'(1));
        idle(10);
        checkOutput("burstCount", 128'(respCyc.size()), 128'(2));
        if (respCyc.size() >= 2) begin
            checkOutput("burstLat0", 128'(respCyc[0] - reqCyc), 128'(4));
            checkOutput("burstData0", respData[0], LINE40);
            checkOutput("burstLat1", 128'(respCyc[1] - reqCyc), 128'(8));
            checkOutput("burstData1", respData[1], LINE00);
        end
        checkOutput("dropSticky", 128'(drop), 128'(1));

        // Write into the line during its own response cycle, then re-request it.
        clearLog();
        reqCyc = cyc;
        applyStimulus(1'b1, 32'h00000040, 1'b0, 32'h0, 32'h0);
        idle(3);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h00000040, 1'b0, 32'h0, 32'h0);
        idle(6);
        checkOutput("rawCount", 128'(respCyc.size()), 128'(2));
        if (respCyc.size() >= 2) begin
            checkOutput("rawLat0", 128'(respCyc[0] - reqCyc), 128'(4));
            checkOutput("rawOldData", respData[0], LINE40);
            checkOutput("rawLat1", 128'(respCyc[1] - reqCyc), 128'(9));
            checkOutput("rawNewData", respData[1], LINE40NEW);
        end

        // Reset while a request is waiting: it must never respond.
        clearLog();
        applyStimulus(1'b1, 32'h00000040, 1'b0, 32'h0, 32'h0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(8);
        checkOutput("abortCount", 128'(respCyc.size()), 128'(0));
        checkOutput("abortReady", 128'(memReadReady), 128'(1));
        checkOutput("abortDrop",  128'(drop), 128'(0));

        clearLog();
        reqCyc = cyc;
        applyStimulus(1'b1, 32'h00000040, 1'b0, 32'h0, 32'h0);
        idle(6);
        checkOutput("postResetCount", 128'(respCyc.size()), 128'(1));
        if (respCyc.size() >= 1) begin
            checkOutput("postResetLat", 128'(respCyc[0] - reqCyc), 128'(4));
            checkOutput("postResetData", respData[0], LINE40NEW);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
